// File: rtl/vref_pkg.sv
// ============================================================================
// vref_pkg : shared types and constants for the multi-channel vREF model
// Revision : 1.0
// ============================================================================
`default_nettype none

package vref_pkg;

  localparam int VrefCalibrationWidth = 5;
  localparam int VrefMidscale         = 1 << (VrefCalibrationWidth - 1);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_STARTUP  = 2'd1,
    ST_SLEW     = 2'd2,
    ST_SETTLED  = 2'd3
  } vref_state_e;

endpackage

`default_nettype wire

// File: rtl/vref_channel.sv
// ============================================================================
// vref_channel : one reference channel - startup delay, slew limiting, settle
// Revision     : 1.0
// ============================================================================
`default_nettype none

module vref_channel
  import vref_pkg::*;
#(
  parameter int CAL_W          = VrefCalibrationWidth,
  parameter int VNOMINAL_MV    = 800,
  parameter int VLSB_MV        = 8,
  parameter int SLEW_DIV       = 4,
  parameter int STARTUP_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CAL_W-1:0] wr_code_i,
  output integer           vout_mv_o,
  output logic             settled_o
);

  localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int DV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [CAL_W-1:0] MID = {1'b1, {(CAL_W-1){1'b0}}};

  function automatic integer to_mv(input logic [CAL_W-1:0] code);
    return $rtoi(real'(VNOMINAL_MV) - real'(2 ** (CAL_W - 1)) * real'(VLSB_MV)
                 + real'(int'(code)) * real'(VLSB_MV));
  endfunction

  vref_state_e      state;
  logic [CAL_W-1:0] target;
  logic [CAL_W-1:0] cur_code;
  logic [SU_W-1:0]  su_cnt;
  logic [DV_W-1:0]  div;
  logic [CAL_W-1:0] tgt_eff;
  logic [CAL_W-1:0] step_code;

  // A write landing this cycle steers decisions immediately (mid-slew retarget).
  assign tgt_eff   = wr_i ? wr_code_i : target;
  assign step_code = (tgt_eff > cur_code) ? cur_code + 1'b1 : cur_code - 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_OFF;
      target    <= MID;
      cur_code  <= MID;
      su_cnt    <= '0;
      div       <= '0;
      vout_mv_o <= 0;
      settled_o <= 1'b0;
    end else begin
      if (wr_i) target <= wr_code_i;
      if (!en_i) begin
        state     <= ST_OFF;
        cur_code  <= MID;
        su_cnt    <= '0;
        div       <= '0;
        vout_mv_o <= 0;
        settled_o <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state    <= ST_STARTUP;
            su_cnt   <= SU_W'(STARTUP_CYCLES - 1);
            cur_code <= MID;
          end
          ST_STARTUP: begin
            if (su_cnt == '0) begin
              div       <= '0;
              vout_mv_o <= to_mv(cur_code);
              if (cur_code == tgt_eff) begin
                state     <= ST_SETTLED;
                settled_o <= 1'b1;
              end else begin
                state <= ST_SLEW;
              end
            end else begin
              su_cnt <= su_cnt - 1'b1;
            end
          end
          ST_SLEW: begin
            if (tgt_eff == cur_code) begin
              state     <= ST_SETTLED;
              settled_o <= 1'b1;
              div       <= '0;
            end else if (div == DV_W'(SLEW_DIV - 1)) begin
              div       <= '0;
              cur_code  <= step_code;
              vout_mv_o <= to_mv(step_code);
              if (step_code == tgt_eff) begin
                state     <= ST_SETTLED;
                settled_o <= 1'b1;
              end
            end else begin
              div <= div + 1'b1;
            end
          end
          ST_SETTLED: begin
            if (tgt_eff != cur_code) begin
              state     <= ST_SLEW;
              settled_o <= 1'b0;
              div       <= '0;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vref_multich.sv
// ============================================================================
// vref_multich : multi-channel vREF model - write decode, error flag, channels
// Revision     : 1.0
// ============================================================================
`default_nettype none

module vref_multich
  import vref_pkg::*;
#(
  parameter int NCH            = 2,
  parameter int CAL_W          = VrefCalibrationWidth,
  parameter int VNOMINAL_MV    = 800,
  parameter int VLSB_MV        = 8,
  parameter int SLEW_DIV       = 4,
  parameter int STARTUP_CYCLES = 8,
  parameter int CH_W           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   en_i,
  input  logic             cal_valid_i,
  output logic             cal_ready_o,
  input  logic [CH_W-1:0]  cal_ch_i,
  input  logic [CAL_W-1:0] cal_code_i,
  output logic             cal_err_o,
  output integer           vout_mv_o [NCH],
  output logic [NCH-1:0]   settled_o
);

  logic accept;
  logic bad_ch;

  assign accept = cal_valid_i & cal_ready_o;
  assign bad_ch = int'(cal_ch_i) >= NCH;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cal_ready_o <= 1'b0;
      cal_err_o   <= 1'b0;
    end else begin
      cal_ready_o <= 1'b1;
      if (accept && bad_ch) cal_err_o <= 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr;
    assign wr = accept && !bad_ch && (int'(cal_ch_i) == g);

    vref_channel #(
      .CAL_W          (CAL_W),
      .VNOMINAL_MV    (VNOMINAL_MV),
      .VLSB_MV        (VLSB_MV),
      .SLEW_DIV       (SLEW_DIV),
      .STARTUP_CYCLES (STARTUP_CYCLES)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i[g]),
      .wr_i      (wr),
      .wr_code_i (cal_code_i),
      .vout_mv_o (vout_mv_o[g]),
      .settled_o (settled_o[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_vref_multich.sv
// ============================================================================
// tb_vref_multich : directed self-checking bench for vref_multich (NCH=3)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_vref_multich;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       cal_valid;
  logic       cal_ready;
  logic [1:0] cal_ch;
  logic [4:0] cal_code;
  logic       cal_err;
  integer     vout [3];
  logic [2:0] settled;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vref_multich #(
    .NCH            (3),
    .CAL_W          (5),
    .VNOMINAL_MV    (800),
    .VLSB_MV        (8),
    .SLEW_DIV       (4),
    .STARTUP_CYCLES (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cal_valid_i (cal_valid),
    .cal_ready_o (cal_ready),
    .cal_ch_i    (cal_ch),
    .cal_code_i  (cal_code),
    .cal_err_o   (cal_err),
    .vout_mv_o   (vout),
    .settled_o   (settled)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle write; returns just after the accepting edge.
  task automatic write(input logic [1:0] ch, input logic [4:0] code);
    cal_valid = 1'b1;
    cal_ch    = ch;
    cal_code  = code;
    tick();
    cal_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 3'b000; cal_valid = 1'b0; cal_ch = '0; cal_code = '0;

    // Reset
    tick(3);
    chk("rst_vout0", vout[0], 0);
    chk("rst_vout1", vout[1], 0);
    chk("rst_settled", int'(settled), 0);
    chk("rst_err", int'(cal_err), 0);
    chk("rst_ready", int'(cal_ready), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(cal_ready), 1);

    // Enable ch0, startup 8 cycles
    en = 3'b001;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("startup_vout_e%0d", i), vout[0], 0);
      chk($sformatf("startup_settled_e%0d", i), int'(settled[0]), 0);
      if (i < 7) tick();
    end
    tick();
    chk("startup_done_vout", vout[0], 800);
    chk("startup_done_settled", int'(settled[0]), 1);
    chk("ch1_stays_off", vout[1], 0);
    chk("ch1_not_settled", int'(settled[1]), 0);

    // Write code 20 -> slew 800 -> 832
    write(2'd0, 5'd20);                      // edge W
    chk("slew_start_settled", int'(settled[0]), 0);
    tick(3);
    chk("slew_w3", vout[0], 800);
    tick();
    chk("slew_w4", vout[0], 808);
    tick(4);
    chk("slew_w8", vout[0], 816);
    chk("slew_w8_settled", int'(settled[0]), 0);

    // Retarget to 14 at W+9; divider phase unchanged
    write(2'd0, 5'd14);                      // edge W+9
    tick(2);
    chk("retgt_w11", vout[0], 816);
    tick();
    chk("retgt_w12", vout[0], 808);
    tick(4);
    chk("retgt_w16", vout[0], 800);
    tick(4);
    chk("retgt_w20", vout[0], 792);
    chk("retgt_w20_settled", int'(settled[0]), 0);
    tick(4);
    chk("retgt_w24", vout[0], 784);
    chk("retgt_w24_settled", int'(settled[0]), 1);

    // Out-of-range channel write
    write(2'd3, 5'd5);
    chk("err_set", int'(cal_err), 1);
    chk("err_ch0_vout", vout[0], 784);
    chk("err_ch0_settled", int'(settled[0]), 1);
    tick(2);
    chk("err_sticky", int'(cal_err), 1);
    chk("err_ch0_still", vout[0], 784);

    // Drop enable mid-slew, re-enable and slew to stored 20
    write(2'd0, 5'd20);
    tick(4);
    chk("pre_drop_vout", vout[0], 792);
    en = 3'b000;
    tick();
    chk("drop_vout", vout[0], 0);
    chk("drop_settled", int'(settled[0]), 0);
    en = 3'b001;
    tick(8);
    chk("reen_startup_vout", vout[0], 0);
    tick();
    chk("reen_mid_vout", vout[0], 800);
    chk("reen_mid_settled", int'(settled[0]), 0);
    tick(4);
    chk("reen_step1", vout[0], 808);
    tick(12);
    chk("reen_final", vout[0], 832);
    chk("reen_final_settled", int'(settled[0]), 1);

    // Reset mid-slew
    write(2'd0, 5'd10);
    tick(4);
    chk("pre_rst_vout", vout[0], 824);
    rst = 1'b1;
    tick();
    chk("midrst_vout", vout[0], 0);
    chk("midrst_settled", int'(settled), 0);
    chk("midrst_err", int'(cal_err), 0);
    chk("midrst_ready", int'(cal_ready), 0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
